// File: rtl/lfsr_gen_multi.sv
// Parametrised PRBS generator: Fibonacci/Galois LFSR with multi-step advance, zero-seed guard,
// period-done pulse. Define LFSR_SYNC_CHECK_EN to add the embedded stream sync checker.
module lfsr_gen_multi #(
  parameter int unsigned          BIT_WIDTH    = 8,
  parameter logic [BIT_WIDTH-1:0] TAPS         = 8'hB8,
  parameter int unsigned          STEPS        = 1,
  parameter logic [BIT_WIDTH-1:0] DEFAULT_SEED = {BIT_WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef LFSR_SYNC_CHECK_EN
  input  logic                 chk_vld,
  input  logic [BIT_WIDTH-1:0] chk_data,
  output logic                 chk_locked,
  output logic [15:0]          chk_err_cnt,
`endif
  input  logic                 enable,
  input  logic                 load_evt,
  input  logic [BIT_WIDTH-1:0] seed_data,
  input  logic                 mode,
  output logic                 lfsr_vld,
  output logic [BIT_WIDTH-1:0] lfsr_data,
  output logic                 lfsr_done,
  output logic                 seed_err
);

  localparam logic [BIT_WIDTH:0] Period = {1'b0, {BIT_WIDTH{1'b1}}};

  function automatic logic [BIT_WIDTH-1:0] shift1(input logic [BIT_WIDTH-1:0] d,
                                                  input logic galois);
    if (galois) return {d[BIT_WIDTH-2:0], 1'b0} ^ (d[BIT_WIDTH-1] ? TAPS : '0);
    return {d[BIT_WIDTH-2:0], ^(d & TAPS)};
  endfunction

  function automatic logic [BIT_WIDTH-1:0] shift_n(input logic [BIT_WIDTH-1:0] d,
                                                   input logic galois);
    logic [BIT_WIDTH-1:0] r;
    r = d;
    for (int i = 0; i < int'(STEPS); i++) r = shift1(r, galois);
    return r;
  endfunction

  logic                 mode_q;
  logic [BIT_WIDTH-1:0] data_q;
  logic [BIT_WIDTH-1:0] cnt_q;
  logic                 vld_q, done_q, seed_err_q;

  logic [BIT_WIDTH:0]   cnt_sum;
  logic                 cnt_wrap;
  logic [BIT_WIDTH-1:0] cnt_d;
  logic                 seed_zero;

  // Shift count wraps modulo the period so done stays aligned when STEPS does not divide it.
  always_comb begin
    cnt_sum   = {1'b0, cnt_q} + (BIT_WIDTH+1)'(STEPS);
    cnt_wrap  = cnt_sum >= Period;
    cnt_d     = cnt_wrap ? BIT_WIDTH'(cnt_sum - Period) : cnt_sum[BIT_WIDTH-1:0];
    seed_zero = (seed_data == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= DEFAULT_SEED;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
      if (load_evt) begin
        data_q     <= seed_zero ? DEFAULT_SEED : seed_data;
        mode_q     <= mode;
        cnt_q      <= '0;
        seed_err_q <= seed_zero;
      end else if (enable) begin
        data_q <= shift_n(data_q, mode_q);
        cnt_q  <= cnt_d;
        vld_q  <= 1'b1;
        done_q <= cnt_wrap;
      end
    end
  end

  assign lfsr_vld  = vld_q;
  assign lfsr_data = data_q;
  assign lfsr_done = done_q;
  assign seed_err  = seed_err_q;

`ifdef LFSR_SYNC_CHECK_EN
  typedef enum logic [0:0] {StHunt, StLock} chk_state_e;

  chk_state_e           chk_state_q;
  logic [BIT_WIDTH-1:0] chk_exp_q;
  logic [1:0]           miss_q;
  logic                 locked_q;
  logic [15:0]          err_cnt_q;

  // Expected value free-runs in lock so one bad word does not derail the following compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_state_q <= StHunt;
      chk_exp_q   <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else if (load_evt) begin
      chk_state_q <= StHunt;
      miss_q      <= '0;
      locked_q    <= 1'b0;
    end else if (chk_vld) begin
      unique case (chk_state_q)
        StHunt: begin
          chk_exp_q <= shift_n(chk_data, mode_q);
          miss_q    <= '0;
          if (chk_data != '0) begin
            chk_state_q <= StLock;
            locked_q    <= 1'b1;
          end
        end
        StLock: begin
          chk_exp_q <= shift_n(chk_exp_q, mode_q);
          if (chk_data != chk_exp_q) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (miss_q == 2'd2) begin
              chk_state_q <= StHunt;
              locked_q    <= 1'b0;
              miss_q      <= '0;
            end else begin
              miss_q <= miss_q + 2'd1;
            end
          end else begin
            miss_q <= '0;
          end
        end
        default: chk_state_q <= StHunt;
      endcase
    end
  end

  assign chk_locked  = locked_q;
  assign chk_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_gen_multi.sv
// Directed bench for lfsr_gen_multi: STEPS=1 and STEPS=4 instances, optional checker loopback.
module tb_lfsr_gen_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, load_evt, mode;
  logic [7:0] seed_data;
  logic       lfsr_vld, lfsr_done, seed_err;
  logic [7:0] lfsr_data;

  logic       en4, ld4;
  logic       vld4, done4, serr4;
  logic [7:0] data4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef LFSR_SYNC_CHECK_EN
  logic        chk_en;
  logic [7:0]  corrupt;
  logic        chk_locked, lock4;
  logic [15:0] chk_err_cnt, err4;
`endif

  lfsr_gen_multi #(.BIT_WIDTH(8), .TAPS(8'hB8), .STEPS(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LFSR_SYNC_CHECK_EN
    .chk_vld   (lfsr_vld & chk_en),
    .chk_data  (lfsr_data ^ corrupt),
    .chk_locked(chk_locked),
    .chk_err_cnt(chk_err_cnt),
`endif
    .enable    (enable),
    .load_evt  (load_evt),
    .seed_data (seed_data),
    .mode      (mode),
    .lfsr_vld  (lfsr_vld),
    .lfsr_data (lfsr_data),
    .lfsr_done (lfsr_done),
    .seed_err  (seed_err)
  );

  lfsr_gen_multi #(.BIT_WIDTH(8), .TAPS(8'hB8), .STEPS(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LFSR_SYNC_CHECK_EN
    .chk_vld   (1'b0),
    .chk_data  (8'h00),
    .chk_locked(lock4),
    .chk_err_cnt(err4),
`endif
    .enable    (en4),
    .load_evt  (ld4),
    .seed_data (8'h01),
    .mode      (1'b0),
    .lfsr_vld  (vld4),
    .lfsr_data (data4),
    .lfsr_done (done4),
    .seed_err  (serr4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp1 [4];
    int         done_cnt, done_at, d4_cnt, d4_first, d4_second, bad_pair;
    exp1 = '{8'h02, 8'h04, 8'h08, 8'h11};

    rst_n = 1'b0; enable = 1'b0; load_evt = 1'b0; mode = 1'b0; seed_data = 8'h00;
    en4 = 1'b0; ld4 = 1'b0;
`ifdef LFSR_SYNC_CHECK_EN
    chk_en = 1'b0; corrupt = 8'h00;
`endif
    #12;
    check("rst_data", lfsr_data, 8'hFF);
    check("rst_vld", lfsr_vld, 0);
    check("rst_done", lfsr_done, 0);
    check("rst_seed_err", seed_err, 0);
`ifdef LFSR_SYNC_CHECK_EN
    check("rst_chk_locked", chk_locked, 0);
    check("rst_chk_err", chk_err_cnt, 0);
`endif
    rst_n = 1'b1;

    // Fibonacci from 0x01
    mode = 1'b0; seed_data = 8'h01; load_evt = 1'b1; tick(); load_evt = 1'b0;
    check("fib_load_data", lfsr_data, 8'h01);
    check("fib_load_vld", lfsr_vld, 0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fib_data%0d", i), lfsr_data, exp1[i]);
      check($sformatf("fib_vld%0d", i), lfsr_vld, 1);
    end
    enable = 1'b0; tick();
    check("hold_vld", lfsr_vld, 0);
    check("hold_data", lfsr_data, 8'h11);

    // Galois from 0x80, mode latched only by load
    mode = 1'b1; seed_data = 8'h80; load_evt = 1'b1; tick(); load_evt = 1'b0;
    enable = 1'b1; tick(); enable = 1'b0;
    check("gal_step1", lfsr_data, 8'hB8);
    mode = 1'b0; tick();
    enable = 1'b1; tick(); enable = 1'b0;
    check("gal_mode_kept", lfsr_data, 8'hC8);

    // Zero seed guard, load beats enable
    seed_data = 8'h00; load_evt = 1'b1; tick(); load_evt = 1'b0;
    check("zero_seed_err", seed_err, 1);
    check("zero_seed_data", lfsr_data, 8'hFF);
    check("zero_seed_vld", lfsr_vld, 0);
    tick();
    check("seed_err_pulse", seed_err, 0);
    seed_data = 8'h5A; load_evt = 1'b1; enable = 1'b1; tick(); load_evt = 1'b0; enable = 1'b0;
    check("load_prio_data", lfsr_data, 8'h5A);
    check("load_prio_vld", lfsr_vld, 0);
    check("load_prio_seed_err", seed_err, 0);

    // Full period (STEPS=1) and STEPS=4 done spacing
    seed_data = 8'h01; load_evt = 1'b1; ld4 = 1'b1; tick(); load_evt = 1'b0; ld4 = 1'b0;
    done_cnt = 0; done_at = 0; d4_cnt = 0; d4_first = 0; d4_second = 0; bad_pair = 0;
    enable = 1'b1; en4 = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      if (i == 129) en4 = 1'b0;
      tick();
      if (lfsr_done) begin done_cnt++; done_at = i; end
      if (lfsr_done && !lfsr_vld) bad_pair++;
      if (done4 && !vld4) bad_pair++;
      if (done4) begin
        d4_cnt++;
        if (d4_cnt == 1) d4_first = i;
        if (d4_cnt == 2) d4_second = i;
      end
    end
    enable = 1'b0;
    check("period_done_cnt", done_cnt, 1);
    check("period_done_at", done_at, 255);
    check("period_data", lfsr_data, 8'h01);
    check("done_without_vld", bad_pair, 0);
    check("s4_done_cnt", d4_cnt, 2);
    check("s4_first_done", d4_first, 64);
    check("s4_second_done", d4_second, 128);

    // Async reset mid-run
    enable = 1'b1; tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", lfsr_data, 8'hFF);
    check("async_rst_vld", lfsr_vld, 0);
    enable = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_data", lfsr_data, 8'hFF);
    check("post_rst_vld", lfsr_vld, 0);

`ifdef LFSR_SYNC_CHECK_EN
    // Loopback checker
    mode = 1'b0; seed_data = 8'h01; load_evt = 1'b1; tick(); load_evt = 1'b0;
    chk_en = 1'b1; enable = 1'b1;
    tick(); tick();
    check("chk_lock", chk_locked, 1);
    tick(); tick(); tick(); tick();
    check("chk_clean_err", chk_err_cnt, 0);
    corrupt = 8'h01; tick(); corrupt = 8'h00;
    check("chk_one_err", chk_err_cnt, 1);
    check("chk_stays_locked", chk_locked, 1);
    tick(); tick();
    check("chk_recovered_err", chk_err_cnt, 1);
    corrupt = 8'h01; tick(); tick(); tick(); corrupt = 8'h00;
    check("chk_unlock", chk_locked, 0);
    check("chk_err_after3", chk_err_cnt, 4);
    tick();
    check("chk_relock", chk_locked, 1);
    tick(); tick(); tick();
    check("chk_relock_err", chk_err_cnt, 4);
    check("chk_relock_held", chk_locked, 1);
    enable = 1'b0; chk_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
